// File: rtl/instruction_fetch.sv
// Instruction fetch unit: one outstanding memory read at a time,
// with a wait-cycle timeout that latches a fault until cleared.
module instruction_fetch #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic        fetch_req,
  input  logic        flush,
  input  logic        fault_clr,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_data,
  input  logic        mem_ready,
  output logic [15:0] ir_out,
  output logic        ir_valid,
  output logic        pc_enable,
  output logic        busy,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERROR
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_state;
  logic [7:0]  r_cnt, w_cnt;
  logic [15:0] r_addr, w_addr;
  logic [15:0] r_ir, w_ir;
  logic        r_rd, w_rd;
  logic        r_valid, w_valid;
  logic        r_pce, w_pce;
  logic        r_busy, w_busy;
  logic        r_fault, w_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_addr  <= 16'h0000;
      r_ir    <= 16'h0000;
      r_rd    <= 1'b0;
      r_valid <= 1'b0;
      r_pce   <= 1'b0;
      r_busy  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_addr  <= w_addr;
      r_ir    <= w_ir;
      r_rd    <= w_rd;
      r_valid <= w_valid;
      r_pce   <= w_pce;
      r_busy  <= w_busy;
      r_fault <= w_fault;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_addr  = r_addr;
    w_ir    = r_ir;
    w_rd    = r_rd;
    w_valid = r_valid;
    w_pce   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (flush) begin
          w_valid = 1'b0;
        end else if (fetch_req) begin
          w_state = S_WAIT;
          w_addr  = pc;
          w_rd    = 1'b1;
          w_valid = 1'b0;
          w_cnt   = 8'd0;
        end
      end
      S_WAIT: begin
        // flush beats ready, ready beats timeout
        if (flush) begin
          w_state = S_IDLE;
          w_rd    = 1'b0;
          w_valid = 1'b0;
        end else if (mem_ready) begin
          w_state = S_IDLE;
          w_ir    = mem_data;
          w_valid = 1'b1;
          w_rd    = 1'b0;
          w_pce   = 1'b1;
        end else if (r_cnt == LP_LAST) begin
          w_state = S_ERROR;
          w_rd    = 1'b0;
          w_valid = 1'b0;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      S_ERROR: begin
        if (flush) w_valid = 1'b0;
        if (fault_clr) begin
          w_state = S_IDLE;
          w_cnt   = 8'd0;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_rd    = 1'b0;
        w_valid = 1'b0;
      end
    endcase
    w_busy  = (w_state != S_IDLE);
    w_fault = (w_state == S_ERROR);
  end

  assign mem_addr  = r_addr;
  assign mem_rd    = r_rd;
  assign ir_out    = r_ir;
  assign ir_valid  = r_valid;
  assign pc_enable = r_pce;
  assign busy      = r_busy;
  assign fault     = r_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios
// with literal expectations, then randomized traffic vs a model.
module tb_instruction_fetch;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = '0;
  logic        fetch_req = 1'b0;
  logic        flush = 1'b0;
  logic        fault_clr = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data = '0;
  logic        mem_ready = 1'b0;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic        pc_enable;
  logic        busy;
  logic        fault;

  int n_vec = 0;
  int n_err = 0;

  // model: an outstanding fetch and how long it has waited
  bit          m_pend, m_fault, m_rd, m_valid, m_pce;
  int          m_waited;
  logic [15:0] m_addr, m_ir;

  always #5 clk = ~clk;

  instruction_fetch #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req),
    .flush(flush), .fault_clr(fault_clr), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .ir_out(ir_out), .ir_valid(ir_valid), .pc_enable(pc_enable),
    .busy(busy), .fault(fault)
  );

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_pend = 0; m_fault = 0; m_rd = 0; m_valid = 0; m_pce = 0;
    m_waited = 0; m_addr = '0; m_ir = '0;
  endtask

  task automatic m_step();
    m_pce = 0;
    if (rst) begin
      m_reset();
    end else if (m_fault) begin
      if (flush) m_valid = 0;
      if (fault_clr) m_fault = 0;
    end else if (m_pend) begin
      if (flush) begin
        m_pend = 0; m_rd = 0; m_valid = 0;
      end else if (mem_ready) begin
        m_pend = 0; m_rd = 0; m_valid = 1; m_pce = 1; m_ir = mem_data;
      end else if (m_waited + 1 == TMO) begin
        m_pend = 0; m_fault = 1; m_rd = 0; m_valid = 0;
      end else begin
        m_waited++;
      end
    end else if (flush) begin
      m_valid = 0;
    end else if (fetch_req) begin
      m_pend = 1; m_waited = 0; m_addr = pc; m_rd = 1; m_valid = 0;
    end
  endtask

  task automatic cmp_model();
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_rd", 16'(mem_rd), 16'(m_rd));
    chk("ir_out", ir_out, m_ir);
    chk("ir_valid", 16'(ir_valid), 16'(m_valid));
    chk("pc_enable", 16'(pc_enable), 16'(m_pce));
    chk("busy", 16'(busy), 16'(m_pend | m_fault));
    chk("fault", 16'(fault), 16'(m_fault));
  endtask

  task automatic step();
    @(posedge clk);
    m_step();
    #1;
    cmp_model();
  endtask

  task automatic idle_in();
    fetch_req = 0; flush = 0; fault_clr = 0; mem_ready = 0;
  endtask

  int busy_cnt, pulses, consec;
  bit prev_pce;

  initial begin
    m_reset();
    #1;
    cmp_model();
    chk("reset_addr", mem_addr, 16'h0000);
    step();
    #2 rst = 0;

    // single fetch with ready tied high
    pc = 16'h0010; mem_data = 16'hA5A5; mem_ready = 1; fetch_req = 1;
    step();
    chk("t1_rd", 16'(mem_rd), 16'd1);
    chk("t1_addr", mem_addr, 16'h0010);
    fetch_req = 0;
    step();
    chk("t1_ir", ir_out, 16'hA5A5);
    chk("t1_pce", 16'(pc_enable), 16'd1);
    step();
    chk("t1_pce_drop", 16'(pc_enable), 16'd0);

    // ready delayed three cycles
    idle_in(); busy_cnt = 0; pc = 16'h0020; fetch_req = 1;
    step(); busy_cnt += int'(busy);
    fetch_req = 0;
    repeat (3) begin step(); busy_cnt += int'(busy); end
    mem_ready = 1; mem_data = 16'h1234;
    step(); busy_cnt += int'(busy);
    chk("t2_busy_cycles", 16'(busy_cnt), 16'd4);
    chk("t2_ir", ir_out, 16'h1234);
    chk("t2_fault", 16'(fault), 16'd0);

    // timeout, flush cannot exit, fault_clr does
    idle_in(); mem_data = 16'h7777; fetch_req = 1;
    step();
    fetch_req = 0;
    repeat (TMO - 1) step();
    chk("t3_not_yet", 16'(fault), 16'd0);
    step();
    chk("t3_fault", 16'(fault), 16'd1);
    chk("t3_rd", 16'(mem_rd), 16'd0);
    flush = 1; step(); flush = 0;
    chk("t3_flush_stays", 16'(fault), 16'd1);
    fault_clr = 1; step(); fault_clr = 0;
    chk("t3_clr", 16'(fault), 16'd0);
    chk("t3_clr_busy", 16'(busy), 16'd0);

    // flush beats ready
    idle_in(); fetch_req = 1; step(); fetch_req = 0;
    flush = 1; mem_ready = 1; mem_data = 16'hBEEF;
    step();
    chk("t4_ir_kept", ir_out, 16'h1234);
    chk("t4_valid", 16'(ir_valid), 16'd0);
    chk("t4_pce", 16'(pc_enable), 16'd0);
    idle_in();

    // asynchronous reset mid-wait
    pc = 16'h00F0; fetch_req = 1; step(); fetch_req = 0;
    #2 rst = 1;
    #1;
    m_reset();
    chk("t5_addr", mem_addr, 16'h0000);
    chk("t5_rd", 16'(mem_rd), 16'd0);
    chk("t5_busy", 16'(busy), 16'd0);
    chk("t5_ir", ir_out, 16'h0000);
    cmp_model();
    step();
    #2 rst = 0;

    // back-to-back fetches: 10 cycles -> 5 pulses
    mem_ready = 1; fetch_req = 1; pulses = 0; consec = 0; prev_pce = 0;
    repeat (10) begin
      step();
      if (pc_enable) pulses++;
      if (pc_enable && prev_pce) consec++;
      prev_pce = pc_enable;
    end
    chk("t6_pulses", 16'(pulses), 16'd5);
    chk("t6_consec", 16'(consec), 16'd0);
    idle_in();
    step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      pc        = 16'($urandom);
      mem_data  = 16'($urandom);
      fetch_req = ($urandom_range(0, 2) != 0);
      mem_ready = ($urandom_range(0, 6) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      fault_clr = ($urandom_range(0, 5) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0;
    idle_in();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
